// File: rtl/pose_recorder_if.sv
// Signal bundle between the position generator / PWM stage and the pose
// recorder: mode switch, button levels, live duties in; stored duties out.
interface pose_recorder_if #(
    parameter int DW = 6,
    parameter int AW = 4
);
    logic          Storage_Sw;
    logic          Up_deb;
    logic          Down_deb;
    logic          Left_deb;
    logic          Right_deb;
    logic [DW-1:0] Duty_X;
    logic [DW-1:0] Duty_Y;
    logic [DW-1:0] DC_X;
    logic [DW-1:0] DC_Y;
    logic [AW:0]   Rec_Count;
    logic          Full;
    logic          Playing;

    modport master (
        output Storage_Sw, Up_deb, Down_deb, Left_deb, Right_deb, Duty_X, Duty_Y,
        input  DC_X, DC_Y, Rec_Count, Full, Playing
    );

    modport slave (
        input  Storage_Sw, Up_deb, Down_deb, Left_deb, Right_deb, Duty_X, Duty_Y,
        output DC_X, DC_Y, Rec_Count, Full, Playing
    );
endinterface

// File: rtl/pose_recorder.sv
// Pose record/playback store: captures the X/Y duty pair on every button
// release while recording, and loops through the captured poses on playback.
module pose_recorder #(
    parameter int DW    = 6,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DWELL = 50000000,
    parameter int TW    = 26
) (
    input  logic             sysclk,
    input  logic             Reset_Sw,
    pose_recorder_if.slave   pif
);

    typedef enum logic [1:0] {
        RECORD   = 2'd0,
        PB_LOAD  = 2'd1,
        PB_DWELL = 2'd2
    } state_t;

    localparam logic [TW-1:0] DWELL_M1 = TW'(DWELL - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TMR_ONE  = {{(TW-1){1'b0}}, 1'b1};

    logic [2*DW-1:0] mem_r [DEPTH];

    state_t          state_r, state_nx_s;
    logic [DW-1:0]   dc_x_r, dc_x_nx_s;
    logic [DW-1:0]   dc_y_r, dc_y_nx_s;
    logic [AW:0]     rec_count_r, rec_count_nx_s;
    logic [AW-1:0]   wr_ptr_r, wr_ptr_nx_s;
    logic [AW-1:0]   rd_ptr_r, rd_ptr_nx_s;
    logic [TW-1:0]   timer_r, timer_nx_s;
    logic            full_r, full_nx_s;
    logic            playing_r;
    logic            btn_any_q_r;
    logic            any_s, rel_s, wr_en_s;
    logic [2*DW-1:0] rd_data_s;

    assign any_s     = pif.Up_deb | pif.Down_deb | pif.Left_deb | pif.Right_deb;
    assign rel_s     = btn_any_q_r & ~any_s;
    assign rd_data_s = mem_r[rd_ptr_r];

    assign pif.DC_X      = dc_x_r;
    assign pif.DC_Y      = dc_y_r;
    assign pif.Rec_Count = rec_count_r;
    assign pif.Full      = full_r;
    assign pif.Playing   = playing_r;

    // Next-state and datapath update for the record/playback sequencer
    always_comb begin
        state_nx_s     = state_r;
        dc_x_nx_s      = dc_x_r;
        dc_y_nx_s      = dc_y_r;
        rec_count_nx_s = rec_count_r;
        wr_ptr_nx_s    = wr_ptr_r;
        rd_ptr_nx_s    = rd_ptr_r;
        timer_nx_s     = timer_r;
        full_nx_s      = full_r;
        wr_en_s        = 1'b0;
        case (state_r)
            RECORD: begin
                if (pif.Storage_Sw) begin
                    // An empty store has nothing to play; a coincident release is dropped either way
                    if (rec_count_r != {(AW+1){1'b0}}) begin
                        state_nx_s  = PB_LOAD;
                        rd_ptr_nx_s = {AW{1'b0}};
                    end else begin
                        state_nx_s = RECORD;
                    end
                end else if (rel_s) begin
                    if (rec_count_r < DEPTH_C) begin
                        wr_en_s        = 1'b1;
                        wr_ptr_nx_s    = wr_ptr_r + PTR_ONE;
                        rec_count_nx_s = rec_count_r + CNT_ONE;
                    end else begin
                        full_nx_s = 1'b1;
                    end
                end else begin
                    state_nx_s = RECORD;
                end
            end
            PB_LOAD: begin
                if (!pif.Storage_Sw) begin
                    state_nx_s = RECORD;
                end else begin
                    dc_x_nx_s  = rd_data_s[2*DW-1:DW];
                    dc_y_nx_s  = rd_data_s[DW-1:0];
                    timer_nx_s = DWELL_M1;
                    state_nx_s = PB_DWELL;
                end
            end
            PB_DWELL: begin
                if (!pif.Storage_Sw) begin
                    state_nx_s = RECORD;
                end else if (timer_r != {TW{1'b0}}) begin
                    timer_nx_s = timer_r - TMR_ONE;
                end else begin
                    // Loop back to the first pose after the last valid entry
                    if ({1'b0, rd_ptr_r} == rec_count_r - CNT_ONE) begin
                        rd_ptr_nx_s = {AW{1'b0}};
                    end else begin
                        rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
                    end
                    state_nx_s = PB_LOAD;
                end
            end
            default: begin
                state_nx_s = RECORD;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge sysclk) begin
        if (Reset_Sw) begin
            state_r     <= RECORD;
            dc_x_r      <= {DW{1'b0}};
            dc_y_r      <= {DW{1'b0}};
            rec_count_r <= {(AW+1){1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            timer_r     <= {TW{1'b0}};
            full_r      <= 1'b0;
            playing_r   <= 1'b0;
            btn_any_q_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            dc_x_r      <= dc_x_nx_s;
            dc_y_r      <= dc_y_nx_s;
            rec_count_r <= rec_count_nx_s;
            wr_ptr_r    <= wr_ptr_nx_s;
            rd_ptr_r    <= rd_ptr_nx_s;
            timer_r     <= timer_nx_s;
            full_r      <= full_nx_s;
            playing_r   <= (state_nx_s != RECORD);
            btn_any_q_r <= any_s;
        end
    end

    // Pose storage; contents need no reset since only entries below Rec_Count are read
    always_ff @(posedge sysclk) begin
        if (wr_en_s && !Reset_Sw) begin
            mem_r[wr_ptr_r] <= {pif.Duty_X, pif.Duty_Y};
        end
    end

endmodule

// File: tb/tb_pose_recorder.sv
// Directed bench for pose_recorder with a small pose model and a scoreboard
// queue of expected DC pairs consumed cycle by cycle during playback.
module tb_pose_recorder;

    localparam int DW    = 6;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int DWELL = 4;
    localparam int TW    = 3;
    localparam int HOLD  = DWELL + 1;

    logic sysclk;
    logic Reset_Sw;

    pose_recorder_if #(.DW(DW), .AW(AW)) pif ();

    pose_recorder #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW), .DWELL(DWELL), .TW(TW)
    ) dut (
        .sysclk   (sysclk),
        .Reset_Sw (Reset_Sw),
        .pif      (pif)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;

    logic [2*DW-1:0] mdl_mem[$];
    logic            mdl_full;
    logic [2*DW-1:0] mdl_dc;
    logic [2*DW-1:0] sb_q[$];

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_count"}, 32'(pif.Rec_Count), 32'(mdl_mem.size()));
        chk({tag, "_full"}, 32'(pif.Full), 32'(mdl_full));
    endtask

    // One press/release of Up with the given duty on the release cycle
    task automatic release_up(input logic [DW-1:0] x, input logic [DW-1:0] y);
        pif.Duty_X = x;
        pif.Duty_Y = y;
        pif.Up_deb = 1'b1;
        step();
        pif.Up_deb = 1'b0;
        step();
        if (mdl_mem.size() < DEPTH) mdl_mem.push_back({x, y});
        else mdl_full = 1'b1;
        chk_status("capture");
    endtask

    task automatic start_play(input int nposes, input int extra);
        pif.Storage_Sw = 1'b1;
        step();
        chk("play_load_playing", 32'(pif.Playing), 32'd1);
        chk("play_load_dc_held", 32'({pif.DC_X, pif.DC_Y}), 32'(mdl_dc));
        for (int k = 0; k < nposes; k++)
            for (int c = 0; c < HOLD; c++) sb_q.push_back(mdl_mem[k % mdl_mem.size()]);
        for (int c = 0; c < extra; c++) sb_q.push_back(mdl_mem[nposes % mdl_mem.size()]);
        while (sb_q.size() > 0) begin
            step();
            mdl_dc = sb_q.pop_front();
            chk("play_dc", 32'({pif.DC_X, pif.DC_Y}), 32'(mdl_dc));
            chk("play_playing", 32'(pif.Playing), 32'd1);
        end
    endtask

    task automatic stop_play();
        pif.Storage_Sw = 1'b0;
        step();
        chk("stop_playing", 32'(pif.Playing), 32'd0);
        chk("stop_dc", 32'({pif.DC_X, pif.DC_Y}), 32'(mdl_dc));
        step();
        chk("stop_dc_frozen", 32'({pif.DC_X, pif.DC_Y}), 32'(mdl_dc));
    endtask

    initial begin
        Reset_Sw       = 1'b1;
        pif.Storage_Sw = 1'b0;
        pif.Up_deb     = 1'b0;
        pif.Down_deb   = 1'b0;
        pif.Left_deb   = 1'b0;
        pif.Right_deb  = 1'b0;
        pif.Duty_X     = '0;
        pif.Duty_Y     = '0;
        mdl_full       = 1'b0;
        mdl_dc         = '0;
        step();
        step();
        Reset_Sw = 1'b0;
        chk("rst_dc", 32'({pif.DC_X, pif.DC_Y}), 32'd0);
        chk("rst_playing", 32'(pif.Playing), 32'd0);
        chk_status("rst");

        // Playback request with an empty store is ignored
        pif.Storage_Sw = 1'b1;
        step();
        step();
        chk("empty_playing", 32'(pif.Playing), 32'd0);
        chk("empty_dc", 32'({pif.DC_X, pif.DC_Y}), 32'd0);
        pif.Storage_Sw = 1'b0;
        step();

        // Three captures, then loop through them once and wrap
        release_up(6'd10, 6'd20);
        release_up(6'd11, 6'd20);
        release_up(6'd12, 6'd21);
        start_play(4, 0);
        stop_play();

        // Append after playback, stop in the middle of a dwell
        release_up(6'd13, 6'd22);
        start_play(5, 2);
        stop_play();

        // Fifth capture overflows the store; playback covers the first four only
        release_up(6'd14, 6'd23);
        start_play(5, 0);
        stop_play();

        // Reset while dwelling on a pose
        start_play(0, 2);
        Reset_Sw = 1'b1;
        step();
        Reset_Sw = 1'b0;
        mdl_mem.delete();
        mdl_full = 1'b0;
        mdl_dc   = '0;
        chk("midrst_playing", 32'(pif.Playing), 32'd0);
        chk("midrst_dc", 32'({pif.DC_X, pif.DC_Y}), 32'd0);
        chk_status("midrst");
        step();
        step();
        chk("midrst_noplay", 32'(pif.Playing), 32'd0);
        pif.Storage_Sw = 1'b0;
        step();

        // Two buttons held: only the final release captures
        pif.Up_deb   = 1'b1;
        pif.Left_deb = 1'b1;
        step();
        pif.Duty_X = 6'd40;
        pif.Duty_Y = 6'd41;
        pif.Up_deb = 1'b0;
        step();
        chk_status("two_btn_first");
        pif.Duty_X   = 6'd30;
        pif.Duty_Y   = 6'd31;
        pif.Left_deb = 1'b0;
        step();
        mdl_mem.push_back({6'd30, 6'd31});
        chk_status("two_btn_last");

        // Release coinciding with the playback request is dropped
        pif.Duty_X = 6'd50;
        pif.Duty_Y = 6'd51;
        pif.Up_deb = 1'b1;
        step();
        pif.Up_deb     = 1'b0;
        pif.Storage_Sw = 1'b1;
        step();
        chk_status("drop_on_play");
        chk("drop_playing", 32'(pif.Playing), 32'd1);
        pif.Storage_Sw = 1'b0;
        step();
        chk("drop_dc", 32'({pif.DC_X, pif.DC_Y}), 32'd0);
        chk_status("drop_after");
        start_play(2, 0);
        stop_play();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
